// File: rtl/enc_menu_pkg.sv
// Shared types and constants for the encoder menu controller.
package enc_menu_pkg;

  // Menu FSM states
  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } menu_state_t;

  // Encoder position and push-button hold counter widths
  localparam int ENC_W = 4;
  localparam int PB_W  = 12;

  // Encoder position seen out of reset
  localparam logic [ENC_W-1:0] ENC_RST_POS = 4'h8;

endpackage

// File: rtl/encoder_menu_ctrl_pb_event_detect.sv
// Push-button event detector: turns the hold counter into a single-cycle
// long-press pulse and a short-press pulse on release. Presses shorter than
// SHORT_MIN are ignored; a release that follows a long event is swallowed.
module pb_event_detect
  import enc_menu_pkg::*;
#(
  parameter int SHORT_MIN  = 20,
  parameter int LONG_PRESS = 1000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [PB_W-1:0] i_pb_cnt,
  output logic            o_short_evt,
  output logic            o_long_evt
);

  localparam logic [PB_W-1:0] SHORT_MIN_C = PB_W'(SHORT_MIN);
  localparam logic [PB_W-1:0] LONG_C      = PB_W'(LONG_PRESS);

  logic [PB_W-1:0] r_pb_last;
  logic            r_long_fired;
  logic            w_released;

  assign w_released  = (i_pb_cnt == '0);
  assign o_long_evt  = (i_pb_cnt == LONG_C) && !r_long_fired;
  assign o_short_evt = w_released && (r_pb_last >= SHORT_MIN_C) &&
                       (r_pb_last < LONG_C) && !r_long_fired;

  // Track the previous hold count and remember that a long event already fired
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pb_last    <= '0;
      r_long_fired <= 1'b0;
    end else begin
      r_pb_last <= i_pb_cnt;
      if (w_released)
        r_long_fired <= 1'b0;
      else if (o_long_evt)
        r_long_fired <= 1'b1;
    end
  end

endmodule

// File: rtl/encoder_menu_ctrl.sv
// Encoder menu controller: browses a bank of parameters with the encoder,
// edits the selected one, and commits it over a valid/ready write port while
// keeping a local shadow copy of every parameter.
// Build option: define ENC_MENU_WRAP_EN to make the selection and the edited
// value wrap around instead of saturating.
module encoder_menu_ctrl
  import enc_menu_pkg::*;
#(
  parameter int N_PARAMS   = 4,
  parameter int PW         = 8,
  parameter int SHORT_MIN  = 20,
  parameter int LONG_PRESS = 1000,
  parameter int PARAM_RST  = 0,
  localparam int SW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ENC_W-1:0]       i_enc_counter,
  input  logic [PB_W-1:0]        i_pb_cnt,
  output logic [SW-1:0]          o_sel_idx,
  output logic                   o_edit_active,
  output logic [PW-1:0]          o_edit_value,
  output logic                   o_cfg_valid,
  output logic [SW-1:0]          o_cfg_addr,
  output logic [PW-1:0]          o_cfg_data,
  input  logic                   i_cfg_ready,
  output logic [N_PARAMS*PW-1:0] o_params
);

  localparam int               SSW         = SW + 6;
  localparam logic [PW-1:0]    PARAM_RST_C = PW'(PARAM_RST);
  localparam logic signed [SSW-1:0] SEL_MAX = SSW'(N_PARAMS - 1);

  logic [ENC_W-1:0]        r_enc_last;
  logic signed [ENC_W-1:0] w_delta;
  logic                    w_short;
  logic                    w_long;
  logic                    w_commit_fire;

  menu_state_t   r_state;
  logic [SW-1:0] r_sel_idx;
  logic          r_edit_active;
  logic [PW-1:0] r_edit_value;
  logic          r_cfg_valid;
  logic [SW-1:0] r_cfg_addr;
  logic [PW-1:0] r_cfg_data;
  logic [PW-1:0] r_params [N_PARAMS];

  logic signed [SSW-1:0] w_sel_sum;
  logic [SW-1:0]         w_sel_next;
  logic [PW-1:0]         w_edit_next;

  // Press-event detection
  pb_event_detect #(
    .SHORT_MIN  (SHORT_MIN),
    .LONG_PRESS (LONG_PRESS)
  ) u_pb (
    .clk         (clk),
    .rstn        (rstn),
    .i_pb_cnt    (i_pb_cnt),
    .o_short_evt (w_short),
    .o_long_evt  (w_long)
  );

  // Modulo-16 difference reinterpreted as signed gives -8..+7 steps
  assign w_delta       = $signed(i_enc_counter - r_enc_last);
  assign w_sel_sum     = $signed({{(SSW-SW){1'b0}}, r_sel_idx}) + SSW'(w_delta);
  assign w_commit_fire = (r_state == COMMIT) && r_cfg_valid && i_cfg_ready;

`ifdef ENC_MENU_WRAP_EN
  localparam logic signed [SSW-1:0] SEL_N = SSW'(N_PARAMS);
  logic signed [SSW-1:0] w_sel_acc;

  // Wrap the selection by repeated compare-and-adjust (works for any N_PARAMS)
  always_comb begin
    w_sel_acc = w_sel_sum;
    for (int k = 0; k < 2 * ENC_W; k++) begin
      if (w_sel_acc[SSW-1])
        w_sel_acc = w_sel_acc + SEL_N;
      else if (w_sel_acc >= SEL_N)
        w_sel_acc = w_sel_acc - SEL_N;
    end
    w_sel_next = w_sel_acc[SW-1:0];
  end

  // Edited value wraps naturally modulo 2^PW
  always_comb begin
    w_edit_next = r_edit_value + PW'(w_delta);
  end
`else
  localparam int ESW = PW + 6;
  logic signed [ESW-1:0] w_edit_sum;

  assign w_edit_sum = $signed({6'b0, r_edit_value}) + ESW'(w_delta);

  // Saturate the selection to 0..N_PARAMS-1
  always_comb begin
    w_sel_next = w_sel_sum[SW-1:0];
    if (w_sel_sum[SSW-1])
      w_sel_next = '0;
    else if (w_sel_sum > SEL_MAX)
      w_sel_next = SEL_MAX[SW-1:0];
  end

  // Saturate the edited value to 0..2^PW-1
  always_comb begin
    w_edit_next = w_edit_sum[PW-1:0];
    if (w_edit_sum[ESW-1])
      w_edit_next = '0;
    else if (|w_edit_sum[ESW-2:PW])
      w_edit_next = '1;
  end
`endif

  // Previous encoder position, tracked in every state
  always_ff @(posedge clk) begin
    if (!rstn)
      r_enc_last <= ENC_RST_POS;
    else
      r_enc_last <= i_enc_counter;
  end

  // Menu FSM with registered outputs; press events take priority over encoder steps
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= BROWSE;
      r_sel_idx     <= '0;
      r_edit_active <= 1'b0;
      r_edit_value  <= '0;
      r_cfg_valid   <= 1'b0;
      r_cfg_addr    <= '0;
      r_cfg_data    <= '0;
    end else begin
      case (r_state)
        BROWSE: begin
          if (w_short) begin
            r_edit_value  <= r_params[r_sel_idx];
            r_edit_active <= 1'b1;
            r_state       <= EDIT;
          end else if (!w_long && (w_delta != '0)) begin
            r_sel_idx <= w_sel_next;
          end
        end
        EDIT: begin
          if (w_short) begin
            r_cfg_valid <= 1'b1;
            r_cfg_addr  <= r_sel_idx;
            r_cfg_data  <= r_edit_value;
            r_state     <= COMMIT;
          end else if (w_long) begin
            r_edit_active <= 1'b0;
            r_state       <= BROWSE;
          end else if (w_delta != '0) begin
            r_edit_value <= w_edit_next;
          end
        end
        COMMIT: begin
          if (r_cfg_valid && i_cfg_ready) begin
            r_cfg_valid   <= 1'b0;
            r_edit_active <= 1'b0;
            r_state       <= BROWSE;
          end
        end
        default: begin
          r_cfg_valid   <= 1'b0;
          r_edit_active <= 1'b0;
          r_state       <= BROWSE;
        end
      endcase
    end
  end

  // Shadow parameter bank, updated only on a completed write handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_PARAMS; i++)
        r_params[i] <= PARAM_RST_C;
    end else if (w_commit_fire) begin
      r_params[r_cfg_addr] <= r_cfg_data;
    end
  end

  for (genvar gi = 0; gi < N_PARAMS; gi++) begin : g_params
    assign o_params[gi*PW +: PW] = r_params[gi];
  end

  assign o_sel_idx     = r_sel_idx;
  assign o_edit_active = r_edit_active;
  assign o_edit_value  = r_edit_value;
  assign o_cfg_valid   = r_cfg_valid;
  assign o_cfg_addr    = r_cfg_addr;
  assign o_cfg_data    = r_cfg_data;

endmodule
